// File: rtl/mem_banked_pkg.sv
// Shared types and default sizes for the banked clearable RAM.
package mem_banked_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_WIDTH      = 4;
  localparam int DEF_BANK_ADDR_WIDTH = 10;
  localparam int DEF_BANK_SEL_WIDTH  = 2;

  function automatic int bank_count(input int sel_width);
    return 1 << sel_width;
  endfunction

endpackage

// File: rtl/mem_banked_clr_bram.sv
// Single-port synchronous BRAM bank: registered read, contents untouched by reset.
module mem_bank_sp #(
  parameter int DW = 4,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_clr_fsm.sv
// Bulk-clear sequencer: walks every bank address once, driving a zero write to all banks.
module mem_clr_fsm
  import mem_banked_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr_start_i,
  output logic                       busy_o,
  output logic                       clr_done_o,
  output logic                       clr_we_o,
  output logic [BANK_ADDR_WIDTH-1:0] clr_addr_o
);

  clr_state_e                 state_q, state_d;
  logic [BANK_ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_o = 1'b0;
    clr_we_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (clr_start_i) state_d = CLEAR;
      end
      CLEAR: begin
        clr_we_o = 1'b1;
        // Terminal compare is the only way out; the counter never runs past depth.
        if (cnt_q == {BANK_ADDR_WIDTH{1'b1}}) begin
          clr_done_o = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + BANK_ADDR_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/mem_banked_clr.sv
// Banked single-port RAM with 1-cycle read handshake and hardware bulk clear.
module mem_banked_clr
  import mem_banked_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
  parameter int BANK_SEL_WIDTH  = DEF_BANK_SEL_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req,
  input  logic                                  we,
  input  logic [BANK_SEL_WIDTH+BANK_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]                 din,
  output logic [DATA_WIDTH-1:0]                 dout,
  output logic                                  rd_valid,
  input  logic                                  clr_start,
  output logic                                  busy,
  output logic                                  clr_done
);

  localparam int ADDR_WIDTH = BANK_SEL_WIDTH + BANK_ADDR_WIDTH;
  localparam int NB         = bank_count(BANK_SEL_WIDTH);

  logic                       clr_we;
  logic [BANK_ADDR_WIDTH-1:0] clr_addr;
  logic                       acc_en, acc_wr, acc_rd;
  logic [BANK_SEL_WIDTH-1:0]  bsel, sel_q;
  logic [BANK_ADDR_WIDTH-1:0] waddr, bank_addr;
  logic [DATA_WIDTH-1:0]      bank_wdata;
  logic [NB-1:0][DATA_WIDTH-1:0] bank_rd;
  logic                       rd_valid_q;

  mem_clr_fsm #(.BANK_ADDR_WIDTH(BANK_ADDR_WIDTH)) u_fsm (
    .clk        (clk),
    .reset      (reset),
    .clr_start_i(clr_start),
    .busy_o     (busy),
    .clr_done_o (clr_done),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // A clear request in an idle cycle takes priority over any access in that cycle.
  assign acc_en     = req && !busy && !clr_start;
  assign acc_wr     = acc_en && we;
  assign acc_rd     = acc_en && !we;
  assign bsel       = addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  assign waddr      = addr[BANK_ADDR_WIDTH-1:0];
  assign bank_addr  = busy ? clr_addr : waddr;
  assign bank_wdata = busy ? '0 : din;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic bank_we;
    assign bank_we = clr_we || (acc_wr && (bsel == BANK_SEL_WIDTH'(b)));
    mem_bank_sp #(.DW(DATA_WIDTH), .AW(BANK_ADDR_WIDTH)) u_bank (
      .clk    (clk),
      .we_i   (bank_we),
      .addr_i (bank_addr),
      .wdata_i(bank_wdata),
      .rdata_o(bank_rd[b])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      sel_q      <= '0;
    end else begin
      rd_valid_q <= acc_rd;
      if (acc_rd) sel_q <= bsel;
    end
  end

  assign rd_valid = rd_valid_q;
  assign dout     = rd_valid_q ? bank_rd[sel_q] : '0;

endmodule

// File: doc/mem_banked_clr.md
Name: mem_banked_clr

Overview:
- Parametrised banked single-port synchronous RAM: 2^BANK_SEL_WIDTH banks of 2^BANK_ADDR_WIDTH x DATA_WIDTH.
- Upper address bits select the bank; the read mux select is registered so it stays aligned with the synchronous bank output.
- Adds a request/valid read handshake and a hardware bulk-clear sequencer that zeroes every location.
- Used as the general scratch/frame memory wherever a flat, clearable, multi-bank store is needed.

Parameters:
DATA_WIDTH, 4, bits per word
BANK_ADDR_WIDTH, 10, address bits inside one bank (depth per bank = 2^BANK_ADDR_WIDTH)
BANK_SEL_WIDTH, 2, bank-select bits (bank count = 2^BANK_SEL_WIDTH); ADDR_WIDTH = BANK_SEL_WIDTH + BANK_ADDR_WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request, sampled each clk
we  input  1  1 = write, 0 = read; qualified by req
addr  input  ADDR_WIDTH  [ADDR_WIDTH-1:BANK_ADDR_WIDTH] = bank, lower bits = word
din  input  DATA_WIDTH  write data
dout  output  DATA_WIDTH  read data; valid when rd_valid=1
rd_valid  output  1  read data strobe
clr_start  input  1  1-cycle pulse, starts bulk clear
busy  output  1  clear in progress; requests ignored
clr_done  output  1  1-cycle pulse on the last clear write

Behaviour:
- Interface fixed: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: rd_valid=0, busy=0, clr_done=0, dout=0, FSM=IDLE, clear counter=0.
- RAM contents are not affected by reset.
- Write: req=1, we=1, busy=0 in cycle N.
  - Only the decoded bank is written at addr[BANK_ADDR_WIDTH-1:0].
  - The data is visible to a read issued in cycle N+1 or later.
- Read: req=1, we=0, busy=0 in cycle N.
  - rd_valid=1 in cycle N+1; dout = word at addr.
  - Latency is exactly 1 cycle.
  - Bank select is registered in cycle N and drives the output mux in N+1.
  - Back-to-back reads give one result per cycle, including across banks.
- dout is forced to 0 whenever rd_valid=0 (gated, not held).
- The write path produces no rd_valid.
- FSM states:
  - IDLE: normal access. clr_start=1 -> CLEAR with counter=0, busy=1 from the next cycle.
  - CLEAR: every bank is written with 0 at the counter address, all banks in parallel, one address per cycle. Counter increments.
    - At counter = 2^BANK_ADDR_WIDTH-1: clr_done=1 for that cycle, next state IDLE, busy=0 next cycle.
    - Full clear takes 2^BANK_ADDR_WIDTH cycles (1024 at defaults).
- Boundary and simultaneous events:
  - clr_start and req in the same IDLE cycle: clear wins, the request is dropped, no rd_valid.
  - clr_start while busy=1: ignored; the counter does not restart.
  - req while busy=1: dropped silently, no RAM write, rd_valid=0.
  - A read issued in the last IDLE cycle before CLEAR still returns rd_valid in the next cycle with pre-clear data.
  - Counter wraps only via the terminal compare; no overflow beyond the bank depth.
  - Reset mid-CLEAR: returns to IDLE immediately, busy=0, no clr_done. Memory is partially cleared; the caller must re-issue clr_start.
  - Writes to the top address (all ones) and bottom address (0) of each bank are legal with no aliasing.

Decomposition:
- Package mem_banked_pkg holds:
  - the state typedef (IDLE, CLEAR);
  - default width localparams;
  - the function computing bank count from BANK_SEL_WIDTH.
- Sub-module mem_clr_fsm holds the state register, address counter, busy and clr_done generation.
- Banks are the existing single-port BRAM instantiated in a generate loop. The bank decoder and read mux are inline, parametrised by BANK_SEL_WIDTH.

Test Plan:
- After reset, write 0xA to addr 0x000, 0x5 to 0x400, 0xC to 0x800, 0x3 to 0xC00; read all four back-to-back -> rd_valid=1 on four consecutive cycles, dout = A,5,C,3 in order, each 1 cycle after its req.
- Write 0xF to 0x3FF and 0x1 to 0x400, then read 0x3FF and 0x400 -> 0xF and 0x1 (bank boundary, no aliasing).
- Fill 8 addresses with non-zero data, pulse clr_start -> busy=1 for 1024 cycles, clr_done pulses once on the 1024th, then all 8 reads return 0.
- During CLEAR, issue write 0x7 to 0x010 and a second clr_start -> write dropped, no restart; busy still falls at 1024 cycles; read 0x010 = 0.
- clr_start and read req in the same cycle -> no rd_valid, busy=1 next cycle.
- Reset asserted at clear cycle 500 -> busy=0 and FSM=IDLE with no clk edge; address 0x000 reads 0, address 0x3FF retains its previous value.
